// File: rtl/pll_reset_sequencer.sv
// Qualifies the raw PLL lock on the PLL output clock and releases core, then peripheral, reset.
// Optional saturating lock-loss counter enabled by defining PLL_LOCK_LOSS_COUNT_EN.
module pll_reset_sequencer #(
    parameter int STABLE_CYCLES   = 1024,
    parameter int PERIPH_DELAY    = 16,
    parameter int SOFT_RST_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       soft_rst_req,
    output logic       core_rst,
    output logic       periph_rst,
    output logic       clk_ready,
    output logic [7:0] lock_loss_cnt
);

    localparam int MAX_AB  = (STABLE_CYCLES > PERIPH_DELAY) ? STABLE_CYCLES : PERIPH_DELAY;
    localparam int MAX_CYC = (MAX_AB > SOFT_RST_CYCLES) ? MAX_AB : SOFT_RST_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DELAY - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST   = CNT_W'(SOFT_RST_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT,
        ST_CORE_UP,
        ST_RUN,
        ST_SOFT
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic             lock_p0;
    logic             lock_sync;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             core_rst_nxt;
    logic             periph_rst_nxt;
    logic             clk_ready_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_p0    <= 1'b0;
            lock_sync  <= 1'b0;
            state      <= ST_HOLD;
            cnt        <= '0;
            core_rst   <= 1'b1;
            periph_rst <= 1'b1;
            clk_ready  <= 1'b0;
        end else begin
            lock_p0    <= pll_lock;
            lock_sync  <= lock_p0;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            core_rst   <= core_rst_nxt;
            periph_rst <= periph_rst_nxt;
            clk_ready  <= clk_ready_nxt;
        end
    end

    // Lock loss outranks soft requests and counter expiry in every post-qualification state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_HOLD: begin
                cnt_nxt = '0;
                if (lock_sync) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (!lock_sync) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_CORE_UP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_CORE_UP: begin
                if (!lock_sync) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end else if (cnt == PERIPH_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                cnt_nxt = '0;
                if (!lock_sync) begin
                    state_nxt = ST_HOLD;
                end else if (soft_rst_req) begin
                    state_nxt = ST_SOFT;
                end
            end
            ST_SOFT: begin
                if (!lock_sync) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end else if (cnt == SOFT_LAST) begin
                    state_nxt = ST_CORE_UP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_HOLD;
                cnt_nxt   = '0;
            end
        endcase

        core_rst_nxt   = !((state_nxt == ST_CORE_UP) || (state_nxt == ST_RUN));
        periph_rst_nxt = (state_nxt != ST_RUN);
        clk_ready_nxt  = (state_nxt == ST_RUN);
    end

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic lock_lost;

    assign lock_lost = !lock_sync &&
                       ((state == ST_CORE_UP) || (state == ST_RUN) || (state == ST_SOFT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_loss_cnt <= 8'd0;
        end else if (lock_lost) begin
            lock_loss_cnt <= sat_inc8(lock_loss_cnt);
        end
    end
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Consumer-side counterpart to the PLL clock monitor: runs on the PLL output clock and turns the raw `pll_lock` indication into qualified, staged reset releases for the logic clocked by that PLL. It synchronizes `pll_lock` and requires it to stay high for a programmable window. It then releases the core reset, followed by the peripheral reset after a further delay. Any later lock loss reasserts both resets. It sits between the PLL/clock monitor and the SoC core/bus reset trees.

## Interface
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before core reset release; ≥1.
- `PERIPH_DELAY`, 16: cycles between core and peripheral reset release; ≥1.
- `SOFT_RST_CYCLES`, 32: length of a software-requested reset; ≥1.
- Counter width is `$clog2` of the maximum of the three parameters, plus 1.
- `clk` input 1: PLL output clock; the only clock.
- `rst` input 1: asynchronous, active-high reset (driven from the monitor's PLL reset).
- `pll_lock` input 1: asynchronous PLL lock indication.
- `soft_rst_req` input 1: single-cycle request for a peripheral+core reset; synchronous to `clk`.
- `core_rst` output 1: active-high reset for the CPU/bus.
- `periph_rst` output 1: active-high reset for peripherals.
- `clk_ready` output 1: high only in RUN.
- `lock_loss_cnt` output 8: saturating count of qualified lock losses (see Configuration).

## Operation
- `pll_lock` passes through a 2-FF synchronizer to produce `lock_sync`. No other path uses raw `pll_lock`.
- **HOLD**
  - Outputs: `core_rst`=1, `periph_rst`=1, counter cleared.
  - `lock_sync`=1 → WAIT, with counter=0.
- **WAIT**
  - Outputs: both resets asserted. Counter increments each cycle.
  - `lock_sync`=0 → HOLD. This loss is not counted.
  - Counter==`STABLE_CYCLES`-1 → CORE_UP, counter=0, `core_rst`<=0.
- **CORE_UP**
  - Outputs: `core_rst`=0, `periph_rst`=1. Counter increments.
  - Counter==`PERIPH_DELAY`-1 → RUN, `periph_rst`<=0, `clk_ready`<=1.
- **RUN**
  - Outputs: all resets released.
  - `soft_rst_req`=1 → SOFT, counter=0, `core_rst`<=1, `periph_rst`<=1, `clk_ready`<=0.
- **SOFT**
  - Outputs: both resets asserted. Counter increments.
  - Counter==`SOFT_RST_CYCLES`-1 → CORE_UP with counter=0. The stability window is not re-run.
- **Lock loss**
  - Applies in CORE_UP, RUN and SOFT: `lock_sync`=0 → HOLD.
  - Both resets are asserted and `clk_ready`=0 at that edge.
  - Counted as a qualified lock loss.
- **Priority:** async `rst` > lock loss > `soft_rst_req` > counter expiry.
- `soft_rst_req` outside RUN is ignored and not remembered.
- Counter never wraps. It is cleared on every state transition.

## Timing
- Reset values (async, immediate on `rst` assertion):
  - state=HOLD, synchronizer=0, `core_rst`=1, `periph_rst`=1, `clk_ready`=0, `lock_loss_cnt`=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Lock qualification: with `pll_lock` rising before edge 1 and held high, `core_rst` falls after edge `STABLE_CYCLES`+3.
- `periph_rst` and `clk_ready` change `PERIPH_DELAY` edges after `core_rst` falls.
- Lock loss: `pll_lock` falling before edge 1 → both resets high and `clk_ready` low after edge 3.
- Soft reset: `soft_rst_req` sampled at edge k in RUN → resets high after edge k.
  - `core_rst` falls after edge k+`SOFT_RST_CYCLES`.
  - `periph_rst` falls after edge k+`SOFT_RST_CYCLES`+`PERIPH_DELAY`.
- `rst` deassertion is asynchronous to the block. The first state update is allowed one edge after release; outputs stay at reset values until the sequence progresses.

## Configuration
- `PLL_LOCK_LOSS_COUNT_EN` defined:
  - `lock_loss_cnt` increments by 1 on each qualified lock loss and saturates at 255.
  - Cleared only by `rst`.
- Not defined:
  - `lock_loss_cnt` is tied to 0 and no counter flops exist.
  - All other behaviour is identical.

## Test plan
All scenarios use `STABLE_CYCLES`=8, `PERIPH_DELAY`=4, `SOFT_RST_CYCLES`=6.
- Clean lock: assert `rst` 3 cycles, release, raise `pll_lock` → `core_rst` falls after edge 11, `periph_rst`/`clk_ready` change after edge 15, counter=0.
- Unstable lock: lock high 5 cycles, low 2, then high → no release during the glitch; release is timed from the final rise; `lock_loss_cnt` stays 0.
- Lock loss in RUN: drop `pll_lock` → resets high 3 edges later; `lock_loss_cnt`=1 (macro on) or 0 (off); re-lock repeats the full 8-cycle window.
- Soft reset: pulse `soft_rst_req` in RUN → resets high next edge; `core_rst` low 6 edges later; `periph_rst` low 4 edges after that. A pulse during SOFT or CORE_UP is ignored.
- Lock loss during SOFT while `soft_rst_req` is asserted on the same edge → HOLD; counter increments once.
- Saturation (macro on): 300 qualified losses → `lock_loss_cnt`=255. Mid-sequence `rst` → all outputs return to reset values immediately.
